// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: PC control, imem req/ack, decode valid/ready
// Handles branch redirects, halt at instruction boundaries and a sticky timeout/misalignment fault.
module fetch_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_write,
  output logic               pc_en,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_data,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               halt,
  output logic               fault,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_ISSUE, S_WAIT, S_HOLD, S_HALTED, S_FAULT
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] timer;
  logic       squash;
  logic       redir_ok, redir_bad, ack_take;

  assign redir_bad = redirect & redirect_target[0];
  assign redir_ok  = redirect & ~redirect_target[0];
  // An ack is only useful if no redirect has made the fetched word stale.
  assign ack_take  = imem_ack & ~squash & ~redirect;
  assign pc_next   = redirect_target;

  always_comb begin
    state_nx = state;
    pc_write = 1'b0;
    pc_en    = 1'b0;
    imem_req = 1'b0;
    busy     = 1'b1;
    case (state)
      S_ISSUE: begin
        if (redir_ok)  state_nx = S_ISSUE;
        else if (halt) state_nx = S_HALTED;
        else           state_nx = S_WAIT;
      end
      S_WAIT: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (ack_take) begin
            pc_en    = 1'b1;
            state_nx = S_HOLD;
          end else begin
            state_nx = S_ISSUE;
          end
        end else if (timer == TIMER_LAST) begin
          state_nx = S_FAULT;
        end
      end
      S_HOLD: begin
        if (redir_ok)      state_nx = S_ISSUE;
        else if (ir_ready) state_nx = halt ? S_HALTED : S_ISSUE;
      end
      S_HALTED: begin
        busy = 1'b0;
        if (!halt) state_nx = S_ISSUE;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    // Redirects are honoured everywhere except FAULT; a misaligned target wins over all.
    if (state != S_FAULT) begin
      pc_write = redir_ok;
      if (redir_bad) begin
        state_nx = S_FAULT;
        pc_en    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_ISSUE;
      imem_addr <= '0;
      ir_data   <= '0;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
      fault     <= 1'b0;
      timer     <= '0;
      squash    <= 1'b0;
    end else begin
      state    <= state_nx;
      ir_valid <= (state_nx == S_HOLD);
      fault    <= (state_nx == S_FAULT);
      if (state == S_ISSUE) imem_addr <= pc_addr;
      if (state == S_WAIT && ack_take) begin
        ir_data <= imem_rdata;
        ir_pc   <= imem_addr;
      end
      if (state == S_WAIT && !imem_ack) timer <= timer + 8'd1;
      else                              timer <= '0;
      // A redirect during an outstanding request lets it finish, then drops the word.
      if (state == S_WAIT) begin
        if (imem_ack)      squash <= 1'b0;
        else if (redir_ok) squash <= 1'b1;
      end else begin
        squash <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_addr;
  logic        pc_write, pc_en;
  logic [15:0] pc_next;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        ir_valid, ir_ready;
  logic [15:0] ir_data, ir_pc;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        halt, fault, busy;

  logic [7:0]  wcnt;
  logic [7:0]  ack_delay;
  logic        ack_en, ack_force;
  int          n_chk = 0;
  int          n_pass = 0;

  fetch_ctrl #(.ADDR_W(16), .INSTR_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_write(pc_write), .pc_en(pc_en),
    .pc_next(pc_next), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data),
    .ir_pc(ir_pc), .redirect(redirect), .redirect_target(redirect_target), .halt(halt),
    .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  // PC register and a memory that acks after ack_delay extra wait cycles.
  always @(posedge clk or posedge rst) begin
    if (rst)           pc_addr <= 16'h0000;
    else if (pc_write) pc_addr <= pc_next;
    else if (pc_en)    pc_addr <= pc_addr + 16'd2;
  end

  always @(posedge clk or posedge rst) begin
    if (rst)                        wcnt <= 8'd0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 8'd1;
    else                            wcnt <= 8'd0;
  end

  assign imem_ack   = ack_force | (imem_req & ack_en & (wcnt == ack_delay));
  assign imem_rdata = imem_addr ^ 16'h5A5A;

  task automatic test_reset;
    rst = 1'b1; ir_ready = 1'b1; redirect = 1'b0; redirect_target = 16'h0000; halt = 1'b0;
    ack_en = 1'b1; ack_delay = 8'd0; ack_force = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if ({imem_req, pc_write, pc_en} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {imem_req, pc_write, pc_en}); else n_pass++;
    n_chk++; if ({ir_valid, fault} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {ir_valid, fault}); else n_pass++;
    n_chk++; if (imem_addr !== 16'h0000 || ir_pc !== 16'h0000 || ir_data !== 16'h0000) $display("FAIL reset_regs: addr %h pc %h data %h want 0", imem_addr, ir_pc, ir_data); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_sequence;
    for (int k = 0; k < 3; k++) begin
      logic [15:0] a;
      a = 16'(2 * k);
      n_chk++; if ({imem_req, pc_en, ir_valid} !== 3'b000) $display("FAIL seq_issue%0d: got %b want 000", k, {imem_req, pc_en, ir_valid}); else n_pass++;
      @(negedge clk); #1;
      n_chk++; if (imem_req !== 1'b1 || imem_addr !== a || pc_en !== 1'b1) $display("FAIL seq_wait%0d: req %b addr %h pc_en %b want 1 %h 1", k, imem_req, imem_addr, pc_en, a); else n_pass++;
      @(negedge clk); #1;
      n_chk++; if (ir_valid !== 1'b1 || ir_pc !== a || ir_data !== (a ^ 16'h5A5A) || pc_en !== 1'b0) $display("FAIL seq_hold%0d: valid %b pc %h data %h pc_en %b want 1 %h %h 0", k, ir_valid, ir_pc, ir_data, pc_en, a, a ^ 16'h5A5A); else n_pass++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_redirect_wait;
    ack_delay = 8'd3;
    @(negedge clk); #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0006) $display("FAIL rw_w1: req %b addr %h want 1 0006", imem_req, imem_addr); else n_pass++;
    @(negedge clk); redirect = 1'b1; redirect_target = 16'h0100; #1;
    n_chk++; if (pc_write !== 1'b1 || pc_next !== 16'h0100 || pc_en !== 1'b0) $display("FAIL rw_pcw: pcw %b next %h pc_en %b want 1 0100 0", pc_write, pc_next, pc_en); else n_pass++;
    @(negedge clk); redirect = 1'b0; #1;
    n_chk++; if (imem_req !== 1'b1 || pc_write !== 1'b0) $display("FAIL rw_w3: req %b pcw %b want 1 0", imem_req, pc_write); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (imem_req !== 1'b1 || imem_ack !== 1'b1 || pc_en !== 1'b0 || imem_addr !== 16'h0006) $display("FAIL rw_ack: req %b ack %b pc_en %b addr %h want 1 1 0 0006", imem_req, imem_ack, pc_en, imem_addr); else n_pass++;
    @(negedge clk); ack_delay = 8'd0; ir_ready = 1'b0; #1;
    n_chk++; if (ir_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL rw_drop: valid %b req %b want 0 0", ir_valid, imem_req); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (imem_addr !== 16'h0100 || pc_en !== 1'b1) $display("FAIL rw_newaddr: addr %h pc_en %b want 0100 1", imem_addr, pc_en); else n_pass++;
  endtask

  task automatic test_hold_stall;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_chk++; if (ir_valid !== 1'b1 || ir_pc !== 16'h0100 || ir_data !== 16'h5B5A) $display("FAIL hold_stable%0d: valid %b pc %h data %h want 1 0100 5b5a", i, ir_valid, ir_pc, ir_data); else n_pass++;
    end
    @(negedge clk); ir_ready = 1'b1; redirect = 1'b1; redirect_target = 16'h0040; #1;
    n_chk++; if (pc_write !== 1'b1 || ir_valid !== 1'b1) $display("FAIL hold_redir: pcw %b valid %b want 1 1", pc_write, ir_valid); else n_pass++;
    @(negedge clk); redirect = 1'b0; #1;
    n_chk++; if (ir_valid !== 1'b0) $display("FAIL hold_drop: valid %b want 0", ir_valid); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (imem_addr !== 16'h0040 || imem_req !== 1'b1) $display("FAIL hold_newaddr: addr %h req %b want 0040 1", imem_addr, imem_req); else n_pass++;
  endtask

  task automatic test_halt;
    @(negedge clk); ack_delay = 8'd2; #1;
    n_chk++; if (ir_valid !== 1'b1 || ir_pc !== 16'h0040) $display("FAIL halt_prev: valid %b pc %h want 1 0040", ir_valid, ir_pc); else n_pass++;
    @(negedge clk); #1;
    @(negedge clk); halt = 1'b1; #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 16'h0042) $display("FAIL halt_w1: req %b addr %h want 1 0042", imem_req, imem_addr); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (imem_req !== 1'b1 || pc_en !== 1'b0) $display("FAIL halt_w2: req %b pc_en %b want 1 0", imem_req, pc_en); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (pc_en !== 1'b1) $display("FAIL halt_w3: pc_en %b want 1", pc_en); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (ir_valid !== 1'b1 || ir_pc !== 16'h0042) $display("FAIL halt_deliver: valid %b pc %h want 1 0042", ir_valid, ir_pc); else n_pass++;
    @(negedge clk); redirect = 1'b1; redirect_target = 16'h0200; #1;
    n_chk++; if (imem_req !== 1'b0 || ir_valid !== 1'b0 || busy !== 1'b0 || pc_write !== 1'b1) $display("FAIL halt_state: req %b valid %b busy %b pcw %b want 0 0 0 1", imem_req, ir_valid, busy, pc_write); else n_pass++;
    @(negedge clk); redirect = 1'b0; halt = 1'b0; #1;
    n_chk++; if (imem_req !== 1'b0 || pc_write !== 1'b0 || busy !== 1'b0) $display("FAIL halt_stay: req %b pcw %b busy %b want 0 0 0", imem_req, pc_write, busy); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (imem_req !== 1'b0 || busy !== 1'b1) $display("FAIL halt_resume: req %b busy %b want 0 1", imem_req, busy); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (imem_addr !== 16'h0200 || imem_req !== 1'b1) $display("FAIL halt_newaddr: addr %h req %b want 0200 1", imem_addr, imem_req); else n_pass++;
  endtask

  task automatic test_timeout;
    int cnt;
    rst = 1'b1; ack_en = 1'b0; halt = 1'b0; ir_ready = 1'b1; redirect = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (fault) break;
      if (imem_req) cnt++;
    end
    n_chk++; if (cnt !== 8) $display("FAIL to_reqcount: got %0d want 8", cnt); else n_pass++;
    n_chk++; if (fault !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0) $display("FAIL to_fault: fault %b req %b busy %b want 1 0 0", fault, imem_req, busy); else n_pass++;
    @(negedge clk); ack_force = 1'b1; #1;
    n_chk++; if (pc_en !== 1'b0 || pc_write !== 1'b0 || ir_valid !== 1'b0 || fault !== 1'b1) $display("FAIL to_lateack: pc_en %b pcw %b valid %b fault %b want 0 0 0 1", pc_en, pc_write, ir_valid, fault); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (fault !== 1'b1 || ir_valid !== 1'b0) $display("FAIL to_sticky: fault %b valid %b want 1 0", fault, ir_valid); else n_pass++;
    ack_force = 1'b0; rst = 1'b1; #1;
    n_chk++; if (fault !== 1'b0) $display("FAIL to_clear: fault %b want 0", fault); else n_pass++;
  endtask

  task automatic test_misaligned;
    rst = 1'b1; ack_en = 1'b1; ack_delay = 8'd0; ir_ready = 1'b0; redirect = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); redirect = 1'b1; redirect_target = 16'h0011; #1;
    n_chk++; if (pc_write !== 1'b0 || ir_valid !== 1'b1) $display("FAIL mis_nopcw: pcw %b valid %b want 0 1", pc_write, ir_valid); else n_pass++;
    @(negedge clk); redirect = 1'b0; #1;
    n_chk++; if (fault !== 1'b1 || ir_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL mis_fault: fault %b valid %b req %b want 1 0 0", fault, ir_valid, imem_req); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_redirect_wait();
    test_hold_stall();
    test_halt();
    test_timeout();
    test_misaligned();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
    $fatal(1);
  end

endmodule
